fu_mc: RTL

- Parametrised, multi-cycle successor to the CGRA processing-element functional unit.
- Keeps the 16-entry opcode map and the branch/merge semantics.
- Adds generic data width, a valid/ready handshake on both sides, an iterative divider that gives real DIV and MOD, and variable shift amounts.
- Sits in each PE between the operand muxes and the PE output register/interconnect.

---
 rtl/fu_mc_if.sv | 30 +++
 rtl/fu_mc.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fu_mc_if.sv
// fu_mc operand/result handshake bundle.
// Master feeds operands and sinks results; slave is the unit.
interface fu_mc_if #(
  parameter int DATA_W = 16
);
  logic [3:0]        op;
  logic              branch_in;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out;
  logic              branch_out;

  modport master (
    output op, branch_in, in_a, in_b,
    output in_valid, out_ready,
    input  in_ready, out_valid,
    input  out, branch_out
  );

  modport slave (
    input  op, branch_in, in_a, in_b,
    input  in_valid, out_ready,
    output in_ready, out_valid,
    output out, branch_out
  );
endinterface

// File: rtl/fu_mc.sv
// CGRA PE functional unit: single-cycle ALU ops plus
// an iterative restoring divider for DIV/MOD.
module fu_mc #(
  parameter int DATA_W     = 16,
  parameter bit SIGNED_SLT = 1'b0,
  parameter int SH_W       = $clog2(DATA_W)
) (
  input logic    clk,
  input logic    rst_n,
  input logic    en,
  fu_mc_if.slave bus
);

  localparam int CW = SH_W + 1;

  localparam logic [3:0] OP_PASS_A = 4'd0;
  localparam logic [3:0] OP_PASS_B = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_MULT   = 4'd4;
  localparam logic [3:0] OP_DIV    = 4'd5;
  localparam logic [3:0] OP_AND    = 4'd6;
  localparam logic [3:0] OP_OR     = 4'd7;
  localparam logic [3:0] OP_MOD    = 4'd8;
  localparam logic [3:0] OP_SHL    = 4'd9;
  localparam logic [3:0] OP_SHR    = 4'd10;
  localparam logic [3:0] OP_BEQ    = 4'd11;
  localparam logic [3:0] OP_BNE    = 4'd12;
  localparam logic [3:0] OP_SLT    = 4'd13;
  localparam logic [3:0] OP_NOT    = 4'd14;
  localparam logic [3:0] OP_MERGE  = 4'd15;

  typedef enum logic {
    IDLE,
    DIV_BUSY
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] out_q;
  logic              br_q;
  logic              ov_q;

  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvs;
  logic [CW-1:0]     cnt;
  logic              is_mod;

  logic              ready;
  logic              accept;
  logic              is_div_op;
  logic [DATA_W-1:0] res;
  logic              br_c;
  logic              lt;
  logic [SH_W-1:0]   sh;

  logic [DATA_W:0]   tmp;
  logic              ge;
  logic [DATA_W-1:0] rem_n;

  assign ready  = rst_n & en & (state == IDLE)
                & (~ov_q | bus.out_ready);
  assign accept = bus.in_valid & ready;

  assign bus.in_ready   = ready;
  assign bus.out_valid  = ov_q;
  assign bus.out        = out_q;
  assign bus.branch_out = br_q;

  assign is_div_op = (bus.op == OP_DIV)
                   | (bus.op == OP_MOD);
  assign sh = bus.in_b[SH_W-1:0];

  assign lt = SIGNED_SLT
            ? ($signed(bus.in_a) < $signed(bus.in_b))
            : (bus.in_a < bus.in_b);

  always_comb begin
    res  = '0;
    br_c = 1'b0;
    unique case (bus.op)
      OP_PASS_A: res = bus.in_a;
      OP_PASS_B: res = bus.in_b;
      OP_ADD:    res = bus.in_a + bus.in_b;
      OP_SUB:    res = bus.in_a - bus.in_b;
      OP_MULT:   res = bus.in_a * bus.in_b;
      OP_AND:    res = bus.in_a & bus.in_b;
      OP_OR:     res = bus.in_a | bus.in_b;
      OP_SHL:    res = bus.in_a << sh;
      OP_SHR:    res = bus.in_a >> sh;
      OP_BEQ: begin
        res  = bus.in_a;
        br_c = (bus.in_a == bus.in_b);
      end
      OP_BNE: begin
        res  = bus.in_a;
        br_c = (bus.in_a != bus.in_b);
      end
      OP_SLT:    res = {{(DATA_W-1){1'b0}}, lt};
      OP_NOT:    res = ~bus.in_a;
      OP_MERGE:  res = bus.branch_in ? bus.in_a
                                     : bus.in_b;
      default:   res = '0;
    endcase
  end

  // Zero divisor always subtracts: quotient all ones, rem = a.
  assign tmp   = {rem, quo[DATA_W-1]};
  assign ge    = (tmp >= {1'b0, dvs});
  assign rem_n = ge ? (tmp[DATA_W-1:0] - dvs)
                    : tmp[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      out_q  <= '0;
      br_q   <= 1'b0;
      ov_q   <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      is_mod <= 1'b0;
    end else if (en) begin
      if (ov_q & bus.out_ready)
        ov_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_div_op) begin
              state  <= DIV_BUSY;
              rem    <= '0;
              quo    <= bus.in_a;
              dvs    <= bus.in_b;
              cnt    <= CW'(DATA_W);
              is_mod <= (bus.op == OP_MOD);
            end else begin
              out_q <= res;
              br_q  <= br_c;
              ov_q  <= 1'b1;
            end
          end
        end
        DIV_BUSY: begin
          if (cnt == '0) begin
            out_q <= is_mod ? rem : quo;
            br_q  <= 1'b0;
            ov_q  <= 1'b1;
            state <= IDLE;
          end else begin
            rem <= rem_n;
            quo <= {quo[DATA_W-2:0], ge};
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
